// File: rtl/mini_uart.sv
// mini_uart: WISHBONE-style 8N1 UART with TX holding register, 1-byte RX buffer,
// line status and separate TX/RX divisors. Define UART_IRQ_EN to build the IER/IRQ path.
module mini_uart #(
  parameter int unsigned DIV_RESET = 217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  off,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        stb,
  input  logic        we,
  output logic        ack,
  input  logic        rxd,
  output logic        txd,
  output logic        IRQ_data_complete
);

  localparam logic [15:0] DIV_INIT = DIV_RESET[15:0];

  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_IER  = 3'd1;
  localparam logic [2:0] OFF_LSR  = 3'd2;
  localparam logic [2:0] OFF_DIVR = 3'd3;
  localparam logic [2:0] OFF_DIVT = 3'd4;

  // Divisors below 2 would make half-bit timing collapse to zero clocks.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

  logic wr, rd;
  logic wr_data, rd_data, rd_lsr;

  assign wr      = stb & we;
  assign rd      = stb & ~we;
  assign wr_data = wr && (off == OFF_DATA);
  assign rd_data = rd && (off == OFF_DATA);
  assign rd_lsr  = rd && (off == OFF_LSR);
  assign ack     = stb;

  logic unused_din;
  assign unused_din = ^din[31:16];

  logic [15:0] divr_d, divr_q;
  logic [15:0] divt_d, divt_q;

  always_comb begin
    divr_d = divr_q;
    divt_d = divt_q;
    if (wr && (off == OFF_DIVR)) divr_d = din[15:0];
    if (wr && (off == OFF_DIVT)) divt_d = din[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divr_q <= DIV_INIT;
      divt_q <= DIV_INIT;
    end else begin
      divr_q <= divr_d;
      divt_q <= divt_d;
    end
  end

`ifdef UART_IRQ_EN
  logic ier_d, ier_q;

  always_comb begin
    ier_d = ier_q;
    if (wr && (off == OFF_IER)) ier_d = din[0];
  end

  always_ff @(posedge clk) begin
    if (rst) ier_q <= 1'b0;
    else     ier_q <= ier_d;
  end
`else
  logic ier_q;
  assign ier_q = 1'b0;
`endif

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_t;

  tx_state_t   tx_state_q;
  logic        txd_q;
  logic        thre_q;
  logic [8:0]  tx_shift_q;
  logic [3:0]  tx_bit_q;
  logic [15:0] tx_cnt_q;
  logic [15:0] tx_div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      txd_q      <= 1'b1;
      thre_q     <= 1'b1;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'd2;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_data) begin
            tx_shift_q <= {1'b1, din[7:0]};
            thre_q     <= 1'b0;
            tx_state_q <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          txd_q      <= 1'b0;
          tx_bit_q   <= 4'd0;
          tx_cnt_q   <= 16'd0;
          tx_div_q   <= eff_div(divt_q);
          tx_state_q <= TX_SHIFT;
        end
        TX_SHIFT: begin
          // Divisor is re-sampled only at bit boundaries.
          if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_cnt_q <= 16'd0;
            tx_div_q <= eff_div(divt_q);
            if (tx_bit_q == 4'd9) begin
              txd_q      <= 1'b1;
              thre_q     <= 1'b1;
              tx_state_q <= TX_IDLE;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
              tx_bit_q   <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign txd = txd_q;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  rx_state_t   rx_state_q;
  logic        rxd_s1_q, rxd_s2_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_buf_q;
  logic [2:0]  rx_bit_q;
  logic [15:0] rx_cnt_q;
  logic [15:0] rx_div_q;
  logic        dr_q;
  logic        fe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= 3'd0;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= 16'd2;
      dr_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      // Bus clears come first so a same-edge latch or error overrides them.
      if (rd_data) dr_q <= 1'b0;
      if (rd_lsr)  fe_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxd_s2_q) begin
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= eff_div(divr_q);
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1) begin
            rx_cnt_q <= 16'd0;
            rx_div_q <= eff_div(divr_q);
            rx_bit_q <= 3'd0;
            if (rxd_s2_q) rx_state_q <= RX_IDLE;
            else          rx_state_q <= RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= eff_div(divr_q);
            rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_q <= 16'd0;
            if (rxd_s2_q) begin
              rx_buf_q   <= rx_shift_q;
              dr_q       <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              fe_q       <= 1'b1;
              rx_state_q <= RX_WAITHI;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_WAITHI: begin
          // A stuck-low line must go high before another start bit is accepted.
          if (rxd_s2_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- read mux / irq
  always_comb begin
    dout = 32'd0;
    case (off)
      OFF_DATA: dout = {24'd0, rx_buf_q};
      OFF_IER:  dout = {31'd0, ier_q};
      OFF_LSR:  dout = {26'd0, thre_q, 1'b0, fe_q, 2'd0, dr_q};
      OFF_DIVR: dout = {16'd0, divr_q};
      OFF_DIVT: dout = {16'd0, divt_q};
      default:  dout = 32'd0;
    endcase
  end

`ifdef UART_IRQ_EN
  assign IRQ_data_complete = dr_q & ier_q;
`else
  assign IRQ_data_complete = 1'b0;
`endif

endmodule

// File: tb/tb_mini_uart.sv
// Directed self-checking bench for mini_uart: reset, TX framing, RX, framing
// error, glitch rejection, interrupt and reset during a TX frame.
module tb_mini_uart;

  logic        clk;
  logic        rst;
  logic [2:0]  off;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stb;
  logic        we;
  logic        ack;
  logic        rxd;
  logic        txd;
  logic        irq;

  int n_chk;
  int n_bad;
  logic last_ack;

`ifdef UART_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  mini_uart #(.DIV_RESET(217)) dut (
    .clk               (clk),
    .rst               (rst),
    .off               (off),
    .din               (din),
    .dout              (dout),
    .stb               (stb),
    .we                (we),
    .ack               (ack),
    .rxd               (rxd),
    .txd               (txd),
    .IRQ_data_complete (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    off = a; din = d; stb = 1'b1; we = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    off = a; stb = 1'b1; we = 1'b0;
    #1;
    d = dout;
    last_ack = ack;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[0];
      fr  = fr >> 1;
      repeat (217) @(posedge clk);
    end
    #1;
  endtask

  logic [31:0] r;
  logic [9:0]  tx_exp;
  int          bi;

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; off = 3'd0; din = 32'd0; rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    bus_read(3'd2, r);
    check("rst_lsr", r, 32'h20);
    check("rst_ack", 32'(last_ack), 32'd1);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);
    bus_read(3'd3, r);
    check("rst_divr", r, 32'd217);
    bus_read(3'd4, r);
    check("rst_divt", r, 32'd217);
    bus_read(3'd1, r);
    check("rst_ier", r, 32'd0);
    bus_read(3'd6, r);
    check("rd_off6", r, 32'd0);

    // transmit 0x37 with an ignored mid-frame write
    bus_write(3'd4, 32'd217);
    bus_write(3'd0, 32'h37);
    off = 3'd2;
    #1;
    check("tx_thre_drop", dout, 32'h00);
    check("tx_txd_pre", 32'(txd), 32'd1);
    @(posedge clk);
    #1;
    tx_exp = {1'b1, 8'h37, 1'b0};
    for (int c = 0; c < 2170; c++) begin
      bi = c / 217;
      if (c % 217 == 0)   check($sformatf("tx_bit%0d_first", bi), 32'(txd), 32'((tx_exp >> bi) & 10'd1));
      if (c % 217 == 216) check($sformatf("tx_bit%0d_last", bi), 32'(txd), 32'((tx_exp >> bi) & 10'd1));
      if (c == 1000 || c == 2169) check("tx_lsr_busy", dout, 32'h00);
      @(negedge clk);
      if (c == 500) begin
        off = 3'd0; din = 32'hFF; stb = 1'b1; we = 1'b1;
      end else begin
        stb = 1'b0; we = 1'b0; off = 3'd2;
      end
      @(posedge clk);
      #1;
    end
    check("tx_lsr_done", dout, 32'h20);
    check("tx_txd_idle", 32'(txd), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    check("tx_no_restart", 32'(txd), 32'd1);

    // receive 0xA5
    bus_write(3'd3, 32'd217);
    send_byte(8'hA5);
    bus_read(3'd2, r);
    check("rx_lsr_dr", r, 32'h21);
    check("rx_irq_ier0", 32'(irq), 32'd0);
    bus_read(3'd0, r);
    check("rx_data", r, 32'hA5);
    bus_read(3'd2, r);
    check("rx_lsr_clr", r, 32'h20);

    // line held low: one framing error, buffer untouched
    rxd = 1'b0;
    repeat (2500) @(posedge clk);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    bus_read(3'd2, r);
    check("fe_lsr", r, 32'h28);
    bus_read(3'd2, r);
    check("fe_clr_lsr", r, 32'h20);
    bus_read(3'd0, r);
    check("fe_buf_kept", r, 32'hA5);

    // short glitch
    rxd = 1'b0;
    repeat (50) @(posedge clk);
    rxd = 1'b1;
    repeat (300) @(posedge clk);
    bus_read(3'd2, r);
    check("glitch_lsr", r, 32'h20);

    // interrupt enabled
    bus_write(3'd1, 32'h1);
    bus_read(3'd1, r);
    check("ier_rd", r, 32'(IRQ_ON));
    send_byte(8'h3C);
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    bus_read(3'd2, r);
    check("irq_lsr", r, 32'h21);
    check("irq_hold", 32'(irq), 32'(IRQ_ON));
    bus_read(3'd0, r);
    check("irq_data", r, 32'h3C);
    check("irq_clr", 32'(irq), 32'd0);

    // interrupt disabled
    bus_write(3'd1, 32'h0);
    send_byte(8'h5A);
    check("irq_off", 32'(irq), 32'd0);
    bus_read(3'd2, r);
    check("irq_off_lsr", r, 32'h21);
    bus_read(3'd0, r);
    check("irq_off_data", r, 32'h5A);

    // reset in the middle of a frame
    bus_write(3'd4, 32'd300);
    bus_write(3'd3, 32'd100);
    bus_write(3'd0, 32'h00);
    repeat (1000) @(posedge clk);
    #1;
    check("mid_txd_low", 32'(txd), 32'd0);
    @(negedge clk);
    rst = 1'b1; off = 3'd2;
    @(posedge clk);
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_lsr", dout, 32'h20);
    @(negedge clk);
    rst = 1'b0;
    bus_read(3'd4, r);
    check("mid_rst_divt", r, 32'd217);
    bus_read(3'd3, r);
    check("mid_rst_divr", r, 32'd217);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
